// File: rtl/alu_cmd_sequencer_pkg.sv
// Shared definitions for the ALU command sequencer: FSM state encoding,
// opcode values, response status codes and the response byte selector.
package alu_cmd_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_GET_A = 3'd1,
    S_GET_B = 3'd2,
    S_CHECK = 3'd3,
    S_EXEC  = 3'd4,
    S_SEND  = 3'd5
  } state_t;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_DIV = 3'd4;

  localparam logic [7:0] STAT_OK    = 8'h00;
  localparam logic [7:0] STAT_BADOP = 8'hE1;
  localparam logic [7:0] STAT_DIV0  = 8'hE2;

  localparam int RESP_LEN = 5;

  // Byte order of a response frame: status, result high, result low, rem, zf.
  function automatic logic [7:0] resp_byte(input logic [2:0]  idx,
                                           input logic [7:0]  status,
                                           input logic [15:0] result,
                                           input logic [7:0]  rem,
                                           input logic        zf);
    logic [7:0] b;
    case (idx)
      3'd0:    b = status;
      3'd1:    b = result[15:8];
      3'd2:    b = result[7:0];
      3'd3:    b = rem;
      3'd4:    b = {7'b0, zf};
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/alu_cmd_sequencer_ctr.sv
// seq_timeout_ctr: cycle counter with terminal-count pulse.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear (has priority over en)
//   en         : count enable
//   tc         : high while en is set and the count sits at COUNT-1
module seq_timeout_ctr #(
  parameter int COUNT = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int W = (COUNT > 1) ? $clog2(COUNT) : 1;
  localparam logic [W-1:0] LAST = W'(COUNT - 1);

  logic [W-1:0] cnt;

  assign tc = en && (cnt == LAST);

  // Saturates at LAST; the owner leaves the counting state on tc.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !tc) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: collects a 3-byte command (opcode, A, B) from the RX
// byte stream, runs it on the external clocked ALU and returns a response
// frame over a valid/ready TX byte interface.
// Ports:
//   clk, rst_n                    : clock, asynchronous active-low reset
//   rx_data, rx_valid             : received byte and its one-cycle strobe
//   tx_data, tx_valid, tx_ready   : response byte stream (valid/ready)
//   alu_a, alu_b, alu_sel         : ALU operands and operation select
//   alu_result, alu_rem, alu_zf   : ALU outputs, valid ALU_LAT cycles later
//   busy                          : high whenever not idle
//   frame_err                     : one-cycle pulse on timeout or overrun
module alu_cmd_sequencer
  import alu_cmd_sequencer_pkg::*;
#(
  parameter int ALU_LAT        = 2,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int OP_MAX         = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [2:0]  alu_sel,
  input  logic [15:0] alu_result,
  input  logic [7:0]  alu_rem,
  input  logic        alu_zf,
  output logic        busy,
  output logic        frame_err
);

  state_t      state, state_n;
  logic [2:0]  opcode, opcode_n;
  logic [7:0]  a_lat, a_lat_n, b_lat, b_lat_n;
  logic [7:0]  status, status_n;
  logic [15:0] result_r, result_n;
  logic [7:0]  rem_r, rem_n;
  logic        zf_r, zf_n;
  logic [2:0]  idx, idx_n, last_idx, last_idx_n;
  logic [7:0]  tx_data_n, alu_a_n, alu_b_n;
  logic [2:0]  alu_sel_n;
  logic        tx_valid_n, busy_n, frame_err_n;

  logic in_frame, to_clr, to_tc, ex_tc;

  assign in_frame = (state == S_GET_A) || (state == S_GET_B);
  // Idle keeps the counter at zero so GET_A always starts from a clean count.
  assign to_clr   = (state == S_IDLE) || (in_frame && rx_valid);

  seq_timeout_ctr #(.COUNT(TIMEOUT_CYCLES)) u_timeout (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (to_clr),
    .en    (in_frame && !rx_valid),
    .tc    (to_tc)
  );

  seq_timeout_ctr #(.COUNT(ALU_LAT)) u_exec_wait (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state != S_EXEC),
    .en    (state == S_EXEC),
    .tc    (ex_tc)
  );

  always_comb begin
    state_n     = state;
    opcode_n    = opcode;
    a_lat_n     = a_lat;
    b_lat_n     = b_lat;
    status_n    = status;
    result_n    = result_r;
    rem_n       = rem_r;
    zf_n        = zf_r;
    idx_n       = idx;
    last_idx_n  = last_idx;
    tx_data_n   = tx_data;
    tx_valid_n  = tx_valid;
    alu_a_n     = alu_a;
    alu_b_n     = alu_b;
    alu_sel_n   = alu_sel;
    frame_err_n = 1'b0;

    case (state)
      S_IDLE: begin
        if (rx_valid) begin
          opcode_n = rx_data[2:0];
          state_n  = S_GET_A;
        end
      end
      S_GET_A: begin
        if (rx_valid) begin
          a_lat_n = rx_data;
          state_n = S_GET_B;
        end else if (to_tc) begin
          frame_err_n = 1'b1;
          state_n     = S_IDLE;
        end
      end
      S_GET_B: begin
        if (rx_valid) begin
          b_lat_n = rx_data;
          state_n = S_CHECK;
        end else if (to_tc) begin
          frame_err_n = 1'b1;
          state_n     = S_IDLE;
        end
      end
      S_CHECK: begin
        idx_n = 3'd0;
        if (int'(opcode) > OP_MAX) begin
          status_n   = STAT_BADOP;
          last_idx_n = 3'd0;
          state_n    = S_SEND;
        end else if ((opcode == OP_DIV) && (b_lat == 8'h00)) begin
          status_n   = STAT_DIV0;
          last_idx_n = 3'd0;
          state_n    = S_SEND;
        end else begin
          status_n   = STAT_OK;
          last_idx_n = 3'(RESP_LEN - 1);
          alu_a_n    = a_lat;
          alu_b_n    = b_lat;
          alu_sel_n  = opcode;
          state_n    = S_EXEC;
        end
      end
      S_EXEC: begin
        if (ex_tc) begin
          result_n = alu_result;
          rem_n    = alu_rem;
          zf_n     = alu_zf;
          state_n  = S_SEND;
        end
      end
      S_SEND: begin
        // Present a byte, wait for acceptance, drop valid for one cycle.
        if (!tx_valid) begin
          tx_valid_n = 1'b1;
          tx_data_n  = resp_byte(idx, status, result_r, rem_r, zf_r);
        end else if (tx_ready) begin
          tx_valid_n = 1'b0;
          if (idx == last_idx) begin
            idx_n   = 3'd0;
            state_n = S_IDLE;
          end else begin
            idx_n = idx + 3'd1;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase

    // Bytes arriving while a command is in flight are discarded.
    if (rx_valid && ((state == S_CHECK) || (state == S_EXEC) || (state == S_SEND))) begin
      frame_err_n = 1'b1;
    end

    busy_n = (state_n != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      opcode    <= '0;
      a_lat     <= '0;
      b_lat     <= '0;
      status    <= '0;
      result_r  <= '0;
      rem_r     <= '0;
      zf_r      <= 1'b0;
      idx       <= '0;
      last_idx  <= '0;
      tx_data   <= '0;
      tx_valid  <= 1'b0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_sel   <= '0;
      busy      <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_n;
      opcode    <= opcode_n;
      a_lat     <= a_lat_n;
      b_lat     <= b_lat_n;
      status    <= status_n;
      result_r  <= result_n;
      rem_r     <= rem_n;
      zf_r      <= zf_n;
      idx       <= idx_n;
      last_idx  <= last_idx_n;
      tx_data   <= tx_data_n;
      tx_valid  <= tx_valid_n;
      alu_a     <= alu_a_n;
      alu_b     <= alu_b_n;
      alu_sel   <= alu_sel_n;
      busy      <= busy_n;
      frame_err <= frame_err_n;
    end
  end

endmodule
